// File: rtl/seg7_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner slice.
package seg7_pkg;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;

endpackage

// File: rtl/seg7_scanner_if.sv
// Bus between the value producer and the scanner, including the pin-side outputs.
interface seg7_scanner_if #(
    parameter int DIGITS = 8
);
    // No ready path: tick and load are single-cycle qualifiers that the
    // scanner always accepts; value/dp_mask only matter while load is high.
    logic                  tick;
    logic [4*DIGITS-1:0]   value;
    logic                  load;
    logic [DIGITS-1:0]     dp_mask;
    logic                  blank_lz;
    logic [DIGITS-1:0]     anodes;
    logic [6:0]            segments;
    logic                  dp_n;

    modport master (
        output tick, value, load, dp_mask, blank_lz,
        input  anodes, segments, dp_n
    );

    modport slave (
        input  tick, value, load, dp_mask, blank_lz,
        output anodes, segments, dp_n
    );
endinterface

// File: rtl/seg7_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment pattern.
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed common-anode hex display scanner with tear-free frame updates,
// inter-digit blanking and leading-zero suppression.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    seg7_scanner_if.slave bus,
    output scan_state_t   dbg_state
);
    localparam int              IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [3:0]      BLANK_INIT = 4'(BLANK_CYCLES);

    logic [4*DIGITS-1:0] shadow, frame;
    logic [DIGITS-1:0]   shadow_dp, frame_dp;
    logic                pending;
    logic [IDX_W-1:0]    idx, idx_nx;
    scan_state_t         state, state_nx;
    logic [3:0]          cnt, cnt_nx;

    logic                accept, wrap;
    logic [3:0]          sel_nib;
    logic                sel_dp, sel_zero, blanked;
    logic [DIGITS-1:0]   zero_from;
    logic [6:0]          seg_dec;
    logic [DIGITS-1:0]   anodes_nx;
    logic [6:0]          seg_nx;
    logic                dp_nx;

    assign dbg_state = state;

    // A tick is honoured while driving, or once the blank interval has run out.
    always_comb begin
        accept   = bus.tick && ((state == SCAN_DRIVE) || (cnt == 4'd0));
        wrap     = accept && (idx == LAST_IDX);
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        if (accept) begin
            idx_nx   = wrap ? '0 : idx + 1'b1;
            state_nx = SCAN_BLANK;
            cnt_nx   = BLANK_INIT;
        end else if (state == SCAN_BLANK) begin
            if (cnt == 4'd0) state_nx = SCAN_DRIVE;
            else             cnt_nx   = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN_BLANK;
            cnt   <= 4'd0;
            idx   <= LAST_IDX;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Shadow absorbs loads at any time; the frame only changes on the wrap tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow    <= '0;
            shadow_dp <= '0;
            frame     <= '0;
            frame_dp  <= '0;
            pending   <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow    <= bus.value;
                shadow_dp <= bus.dp_mask;
            end
            if (wrap) begin
                if (bus.load) begin
                    frame    <= bus.value;
                    frame_dp <= bus.dp_mask;
                end else if (pending) begin
                    frame    <= shadow;
                    frame_dp <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // zero_from[i]: nibbles i..DIGITS-1 of the frame are all zero.
    always_comb begin
        zero_from             = '0;
        zero_from[DIGITS-1]   = (frame[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = (frame[4*i +: 4] == 4'h0) && zero_from[i+1];
        end
    end

    always_comb begin
        sel_nib  = 4'h0;
        sel_dp   = 1'b0;
        sel_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_nib  = frame[4*i +: 4];
                sel_dp   = frame_dp[i];
                sel_zero = zero_from[i];
            end
        end
    end

    hex_to_seg7 u_dec (
        .nibble (sel_nib),
        .seg    (seg_dec)
    );

    assign blanked = bus.blank_lz && (idx != '0) && sel_zero;

    always_comb begin
        anodes_nx = '1;
        seg_nx    = SEG_BLANK;
        dp_nx     = 1'b1;
        if ((state_nx == SCAN_DRIVE) && !blanked) begin
            anodes_nx = ~(DIGITS'(1) << idx);
            seg_nx    = seg_dec;
            dp_nx     = ~sel_dp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.anodes   <= '1;
            bus.segments <= SEG_BLANK;
            bus.dp_n     <= 1'b1;
        end else begin
            bus.anodes   <= anodes_nx;
            bus.segments <= seg_nx;
            bus.dp_n     <= dp_nx;
        end
    end
endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner: scan timing, frame updates, blanking, dp and reset.
module tb_seg7_scanner;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  scan_state_t dbg_state, dbg_state0;
  int          n_checks = 0;
  int          n_fail = 0;

  seg7_scanner_if #(.DIGITS(8)) bus ();
  seg7_scanner_if #(.DIGITS(8)) bus0 ();

  seg7_scanner #(.DIGITS(8), .BLANK_CYCLES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  seg7_scanner #(.DIGITS(8), .BLANK_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus0),
    .dbg_state (dbg_state0)
  );

  assign bus0.tick     = bus.tick;
  assign bus0.value    = bus.value;
  assign bus0.load     = bus.load;
  assign bus0.dp_mask  = bus.dp_mask;
  assign bus0.blank_lz = bus.blank_lz;

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tick sampled at edge t; returns 1ns after edge t+3 where the digit is driven
  task automatic tick_settle();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_settle();
  endtask

  task automatic check_digit(input string tag, input logic [7:0] an, input logic [6:0] sg, input logic dp);
    check({tag, "_an"}, 32'(bus.anodes), 32'(an));
    check({tag, "_seg"}, 32'(bus.segments), 32'(sg));
    check({tag, "_dp"}, 32'(bus.dp_n), 32'(dp));
  endtask

  // one-hot-or-none anode monitor
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      assert ($countones(~bus.anodes) <= 1) else begin
        n_fail++;
        $error("FAIL onehot_anode: observed %0h expected at most one low", bus.anodes);
      end
    end
  end

  initial begin
    bus.tick     = 1'b0;
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.dp_mask  = '0;
    bus.blank_lz = 1'b1;

    // reset state
    step();
    check_digit("rst", 8'hFF, 7'h7F, 1'b1);
    check("rst_state", 32'(dbg_state), 32'(SCAN_BLANK));
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_an", 32'(bus.anodes), 32'hFF);

    // first tick: inactive for the blank interval, digit 0 on edge t+3
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check("t0_an", 32'(bus.anodes), 32'hFF);
    check("t0_an_b0", 32'(bus0.anodes), 32'hFF);
    step();
    check("t1_an", 32'(bus.anodes), 32'hFF);
    check("t1_an_b0", 32'(bus0.anodes), 32'hFE);
    check("t1_seg_b0", 32'(bus0.segments), 32'h40);
    step();
    check("t2_an", 32'(bus.anodes), 32'hFF);
    check("t2_seg", 32'(bus.segments), 32'h7F);
    step();
    check_digit("first", 8'hFE, 7'h40, 1'b1);

    // load A5 mid-frame; not visible until the wrap
    bus.value = 32'h0000_00A5;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    tick_settle();
    check("midframe_d1_an", 32'(bus.anodes), 32'hFF);
    ticks(6);
    tick_settle();
    check_digit("a5_d0", 8'hFE, 7'h12, 1'b1);
    tick_settle();
    check_digit("a5_d1", 8'hFD, 7'h08, 1'b1);
    for (int d = 2; d < 8; d++) begin
      tick_settle();
      check($sformatf("lz_d%0d_an", d), 32'(bus.anodes), 32'hFF);
    end
    tick_settle();
    check_digit("a5_wrap_d0", 8'hFE, 7'h12, 1'b1);

    // load at idx 3: upper digits keep old frame
    ticks(3);
    bus.blank_lz = 1'b0;
    bus.value    = 32'h1234_5678;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
    check_digit("d3_live_lz", 8'hF7, 7'h40, 1'b1);
    tick_settle();
    check_digit("old_d4", 8'hEF, 7'h40, 1'b1);
    ticks(3);
    check_digit("old_d7", 8'h7F, 7'h40, 1'b1);
    tick_settle();
    check_digit("new_d0", 8'hFE, 7'h00, 1'b1);
    tick_settle();
    check_digit("new_d1", 8'hFD, 7'h78, 1'b1);

    // load on the wrap tick itself
    ticks(6);
    bus.value = 32'h0000_00C3;
    bus.tick  = 1'b1;
    bus.load  = 1'b1;
    step();
    bus.tick  = 1'b0;
    bus.load  = 1'b0;
    step();
    step();
    step();
    check_digit("wrapload_d0", 8'hFE, 7'h30, 1'b1);

    // second tick during blank is dropped
    bus.tick = 1'b1;
    step();
    step();
    bus.tick = 1'b0;
    check("drop_blank_an", 32'(bus.anodes), 32'hFF);
    step();
    step();
    check_digit("drop_d1", 8'hFD, 7'h46, 1'b1);

    // decimal point on digit 2 only
    bus.value   = 32'h1234_5678;
    bus.dp_mask = 8'h04;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
    ticks(6);
    tick_settle();
    check_digit("dp_d0", 8'hFE, 7'h00, 1'b1);
    tick_settle();
    check_digit("dp_d1", 8'hFD, 7'h78, 1'b1);
    tick_settle();
    check_digit("dp_d2", 8'hFB, 7'h02, 1'b0);
    tick_settle();
    check_digit("dp_d3", 8'hF7, 7'h12, 1'b1);

    // asynchronous reset mid-drive
    reset_n = 1'b0;
    #1;
    check_digit("async_rst", 8'hFF, 7'h7F, 1'b1);
    step();
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
